// File: rtl/srambus_arbiter.sv
// Two-requester SRAM-bus arbiter: round-robin grant with hold-until-accept,
// plus an in-order owner FIFO that steers returning data to the right port.
module srambus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              m0_req,
  input  logic              m0_ren,
  input  logic              m0_wen,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [MASK_W-1:0] m0_wmask,
  input  logic [2:0]        m0_size,
  input  logic [2:0]        m0_match_id,
  input  logic              m0_data_resp,
  output logic              m0_addr_ok,
  output logic              m0_data_ok,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_ren,
  input  logic              m1_wen,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [MASK_W-1:0] m1_wmask,
  input  logic [2:0]        m1_size,
  input  logic [2:0]        m1_match_id,
  input  logic              m1_data_resp,
  output logic              m1_addr_ok,
  output logic              m1_data_ok,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_req,
  output logic              s_ren,
  output logic              s_wen,
  output logic [ADDR_W-1:0] s_address,
  output logic [DATA_W-1:0] s_wdata,
  output logic [MASK_W-1:0] s_wmask,
  output logic [2:0]        s_size,
  output logic [2:0]        s_match_id,
  output logic              s_data_resp,
  input  logic              s_addr_ok,
  input  logic              s_data_ok,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              err
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              req;
    logic              ren;
    logic              wen;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
    logic [2:0]        size;
    logic [2:0]        match_id;
  } req_t;

  typedef enum logic {ARB, HOLD} state_t;

  state_t           state, state_nxt;
  logic             gnt, lst, sel;
  req_t [1:0]       mreq;
  req_t             gsel;
  logic [DEPTH-1:0] own;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             full, nempty, head, accept, pop, hold_drop;

  assign mreq[0] = {m0_req, m0_ren, m0_wen, m0_address, m0_wdata, m0_wmask, m0_size, m0_match_id};
  assign mreq[1] = {m1_req, m1_ren, m1_wen, m1_address, m1_wdata, m1_wmask, m1_size, m1_match_id};

  // Grant is combinational in ARB so a request can be accepted the cycle it appears.
  always_comb begin
    sel = gnt;
    if (state == ARB) begin
      if (mreq[0].req && mreq[1].req) sel = ~lst;
      else                            sel = mreq[1].req;
    end
  end

  assign gsel      = mreq[sel];
  assign full      = (cnt == CW'(DEPTH));
  assign nempty    = (cnt != '0);
  assign head      = own[rd_ptr];
  assign s_req     = gsel.req & ~full;
  assign accept    = s_req & s_addr_ok;
  assign pop       = s_data_ok & nempty;
  assign hold_drop = (state == HOLD) & ~mreq[gnt].req;

  assign s_ren      = gsel.ren;
  assign s_wen      = gsel.wen;
  assign s_address  = gsel.address;
  assign s_wdata    = gsel.wdata;
  assign s_wmask    = gsel.wmask;
  assign s_size     = gsel.size;
  assign s_match_id = gsel.match_id;

  assign m0_addr_ok = accept & ~sel;
  assign m1_addr_ok = accept &  sel;

  // Return path routed straight from the FIFO head, no register stage.
  assign m0_data_ok  = pop & ~head;
  assign m1_data_ok  = pop &  head;
  assign m0_rdata    = (nempty && !head) ? s_rdata : '0;
  assign m1_rdata    = (nempty &&  head) ? s_rdata : '0;
  assign s_data_resp = nempty & (head ? m1_data_resp : m0_data_resp);

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:  if (s_req && !s_addr_ok)  state_nxt = HOLD;
      HOLD: if (hold_drop || accept) state_nxt = ARB;
      default:                        state_nxt = ARB;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state  <= ARB;
      gnt    <= 1'b0;
      lst    <= 1'b1;
      own    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ARB) gnt <= sel;
      if (accept) begin
        lst         <= sel;
        own[wr_ptr] <= sel;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (accept && !pop)      cnt <= cnt + CW'(1);
      else if (!accept && pop) cnt <= cnt - CW'(1);
      if (hold_drop || (s_data_ok && !nempty)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_srambus_arbiter.sv
// Directed bench for srambus_arbiter: grant order, hold, full blocking,
// in-order data return and error/reset behaviour.
module tb_srambus_arbiter;
  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        m0_req, m0_ren, m0_wen, m0_data_resp;
  logic [31:0] m0_address, m0_wdata;
  logic [3:0]  m0_wmask;
  logic [2:0]  m0_size, m0_match_id;
  logic        m0_addr_ok, m0_data_ok;
  logic [31:0] m0_rdata;
  logic        m1_req, m1_ren, m1_wen, m1_data_resp;
  logic [31:0] m1_address, m1_wdata;
  logic [3:0]  m1_wmask;
  logic [2:0]  m1_size, m1_match_id;
  logic        m1_addr_ok, m1_data_ok;
  logic [31:0] m1_rdata;
  logic        s_req, s_ren, s_wen, s_data_resp;
  logic [31:0] s_address, s_wdata;
  logic [3:0]  s_wmask;
  logic [2:0]  s_size, s_match_id;
  logic        s_addr_ok, s_data_ok;
  logic [31:0] s_rdata;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h2000_0000;

  srambus_arbiter #(.ADDR_W(32), .DATA_W(32), .MASK_W(4), .DEPTH(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .m0_req(m0_req), .m0_ren(m0_ren), .m0_wen(m0_wen), .m0_address(m0_address),
    .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_size(m0_size), .m0_match_id(m0_match_id),
    .m0_data_resp(m0_data_resp), .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_ren(m1_ren), .m1_wen(m1_wen), .m1_address(m1_address),
    .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_size(m1_size), .m1_match_id(m1_match_id),
    .m1_data_resp(m1_data_resp), .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_ren(s_ren), .s_wen(s_wen), .s_address(s_address), .s_wdata(s_wdata),
    .s_wmask(s_wmask), .s_size(s_size), .s_match_id(s_match_id), .s_data_resp(s_data_resp),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata), .err(err)
  );

  always #5 ACLK = ~ACLK;

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic step();
    @(negedge ACLK);
  endtask

  task automatic idle();
    m0_req = 0; m0_ren = 0; m0_wen = 0; m0_address = 0; m0_wdata = 0; m0_wmask = 0;
    m0_size = 0; m0_match_id = 0; m0_data_resp = 0;
    m1_req = 0; m1_ren = 0; m1_wen = 0; m1_address = 0; m1_wdata = 0; m1_wmask = 0;
    m1_size = 0; m1_match_id = 0; m1_data_resp = 0;
    s_addr_ok = 0; s_data_ok = 0; s_rdata = 0;
  endtask

  task automatic do_reset();
    idle();
    ARESET = 1; step(); step();
    ARESET = 0;
  endtask

  task automatic test_reset();
    idle();
    ARESET = 1; step(); #1;
    n_cmp++; if ({s_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok, s_data_resp, err} !== 7'b0) begin
      n_bad++; $display("FAIL reset_in_flags: got %b want 0000000", {s_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok, s_data_resp, err}); end
    step(); ARESET = 0; #1;
    n_cmp++; if ({s_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok, s_data_resp, err} !== 7'b0) begin
      n_bad++; $display("FAIL reset_out_flags: got %b want 0000000", {s_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok, s_data_resp, err}); end
    n_cmp++; if ({s_address, s_wdata, m0_rdata, m1_rdata} !== 128'h0) begin
      n_bad++; $display("FAIL reset_out_buses: got %h want 0", {s_address, s_wdata, m0_rdata, m1_rdata}); end
    step();
  endtask

  // Tie-break alternation, full blocking (incl. same-cycle pop), FIFO order.
  task automatic test_tie_and_full();
    logic e;
    do_reset();
    m0_req = 1; m1_req = 1; m0_ren = 1; m1_ren = 1;
    m0_address = A0; m1_address = A1; s_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      e = i[0]; #1;
      n_cmp++; if ({m0_addr_ok, m1_addr_ok} !== {~e, e}) begin
        n_bad++; $display("FIFO_tie_grant cyc%0d FAIL: got %b want %b", i, {m0_addr_ok, m1_addr_ok}, {~e, e}); end
      n_cmp++; if (s_address !== (e ? A1 : A0)) begin
        n_bad++; $display("FAIL tie_addr cyc%0d: got %h want %h", i, s_address, e ? A1 : A0); end
      step();
    end
    #1;
    n_cmp++; if ({s_req, m0_addr_ok, m1_addr_ok} !== 3'b000) begin
      n_bad++; $display("FAIL full_block: got %b want 000", {s_req, m0_addr_ok, m1_addr_ok}); end
    step();
    s_data_ok = 1; s_rdata = 32'hA5A5_0000; #1;
    n_cmp++; if ({s_req, m0_data_ok, m1_data_ok} !== 3'b010) begin
      n_bad++; $display("FAIL full_pop_block: got %b want 010", {s_req, m0_data_ok, m1_data_ok}); end
    n_cmp++; if (m0_rdata !== 32'hA5A5_0000) begin
      n_bad++; $display("FAIL full_pop_rdata: got %h want a5a50000", m0_rdata); end
    step();
    s_data_ok = 0; #1;
    n_cmp++; if ({s_req, m0_addr_ok, m1_addr_ok} !== 3'b110) begin
      n_bad++; $display("FAIL after_pop_accept: got %b want 110", {s_req, m0_addr_ok, m1_addr_ok}); end
    step();
    m0_req = 0; m1_req = 0; s_addr_ok = 0;
    // Remaining owners in order: 1,0,1,0
    for (int i = 0; i < 4; i++) begin
      e = ~i[0];
      s_data_ok = 1; s_rdata = 32'h100 + i; #1;
      n_cmp++; if ({m0_data_ok, m1_data_ok} !== {~e, e}) begin
        n_bad++; $display("FAIL drain_owner %0d: got %b want %b", i, {m0_data_ok, m1_data_ok}, {~e, e}); end
      n_cmp++; if ((e ? m1_rdata : m0_rdata) !== 32'h100 + i || (e ? m0_rdata : m1_rdata) !== 32'h0) begin
        n_bad++; $display("FAIL drain_rdata %0d: got %h/%h want owner %0d=%h", i, m0_rdata, m1_rdata, e, 32'h100 + i); end
      step();
    end
    s_data_ok = 0; #1;
    n_cmp++; if (err !== 1'b0) begin
      n_bad++; $display("FAIL tie_err: got %b want 0", err); end
  endtask

  task automatic test_hold();
    do_reset();
    m0_address = A0; m1_address = A1;
    m0_req = 1; s_addr_ok = 1; #1;
    n_cmp++; if (m0_addr_ok !== 1'b1) begin
      n_bad++; $display("FAIL hold_pre_m0: got %b want 1", m0_addr_ok); end
    step();
    m1_req = 1; s_addr_ok = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if ({s_req, m0_addr_ok, m1_addr_ok} !== 3'b100 || s_address !== A1) begin
        n_bad++; $display("FAIL hold_keep cyc%0d: got %b addr %h want 100 addr %h", i, {s_req, m0_addr_ok, m1_addr_ok}, s_address, A1); end
      step();
    end
    s_addr_ok = 1; #1;
    n_cmp++; if ({m0_addr_ok, m1_addr_ok} !== 2'b01) begin
      n_bad++; $display("FAIL hold_release: got %b want 01", {m0_addr_ok, m1_addr_ok}); end
    step(); #1;
    n_cmp++; if ({m0_addr_ok, m1_addr_ok} !== 2'b10) begin
      n_bad++; $display("FAIL hold_next_m0: got %b want 10", {m0_addr_ok, m1_addr_ok}); end
    step();
    m0_req = 0; m1_req = 0; s_addr_ok = 0;
    for (int i = 0; i < 3; i++) begin
      s_data_ok = 1; #1;
      n_cmp++; if ({m0_data_ok, m1_data_ok} !== ((i == 1) ? 2'b01 : 2'b10)) begin
        n_bad++; $display("FAIL hold_drain %0d: got %b want %b", i, {m0_data_ok, m1_data_ok}, (i == 1) ? 2'b01 : 2'b10); end
      step();
    end
    s_data_ok = 0;
    // Held requester withdraws: back to ARB and err latches.
    m0_req = 1; step();
    m0_req = 0; #1;
    n_cmp++; if (err !== 1'b0) begin
      n_bad++; $display("FAIL hold_drop_pre: got %b want 0", err); end
    step(); #1;
    n_cmp++; if (err !== 1'b1) begin
      n_bad++; $display("FAIL hold_drop_err: got %b want 1", err); end
  endtask

  task automatic test_return_order();
    do_reset();
    m0_req = 1; m0_data_resp = 1; s_addr_ok = 1; step();
    m0_req = 0; m1_req = 1; step();
    m1_req = 0; s_addr_ok = 0;
    s_data_ok = 1; s_rdata = 32'hDEAD_BEEF; #1;
    n_cmp++; if ({m0_data_ok, m1_data_ok, s_data_resp} !== 3'b101 || m0_rdata !== 32'hDEAD_BEEF || m1_rdata !== 32'h0) begin
      n_bad++; $display("FAIL ret_first: got %b %h %h want 101 deadbeef 0", {m0_data_ok, m1_data_ok, s_data_resp}, m0_rdata, m1_rdata); end
    step();
    s_rdata = 32'h1234_5678; #1;
    n_cmp++; if ({m0_data_ok, m1_data_ok, s_data_resp} !== 3'b010 || m1_rdata !== 32'h1234_5678 || m0_rdata !== 32'h0) begin
      n_bad++; $display("FAIL ret_second: got %b %h %h want 010 0 12345678", {m0_data_ok, m1_data_ok, s_data_resp}, m0_rdata, m1_rdata); end
    step();
    s_data_ok = 0; #1;
    n_cmp++; if ({m0_data_ok, m1_data_ok, s_data_resp, err} !== 4'b0000) begin
      n_bad++; $display("FAIL ret_empty: got %b want 0000", {m0_data_ok, m1_data_ok, s_data_resp, err}); end
    m0_data_resp = 0;
  endtask

  task automatic test_empty_data_ok();
    do_reset();
    s_data_ok = 1; s_rdata = 32'h5555_5555; #1;
    n_cmp++; if ({m0_data_ok, m1_data_ok} !== 2'b00 || {m0_rdata, m1_rdata} !== 64'h0) begin
      n_bad++; $display("FAIL empty_dok_route: got %b %h %h want 00 0 0", {m0_data_ok, m1_data_ok}, m0_rdata, m1_rdata); end
    step();
    s_data_ok = 0; step(); step(); #1;
    n_cmp++; if (err !== 1'b1) begin
      n_bad++; $display("FAIL empty_dok_sticky: got %b want 1", err); end
    ARESET = 1; step(); ARESET = 0; #1;
    n_cmp++; if (err !== 1'b0) begin
      n_bad++; $display("FAIL empty_dok_clear: got %b want 0", err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    s_addr_ok = 1;
    m0_req = 1; step();
    m0_req = 0; m1_req = 1; step();
    m1_req = 0; s_addr_ok = 0;
    ARESET = 1; step(); ARESET = 0; #1;
    n_cmp++; if (err !== 1'b0) begin
      n_bad++; $display("FAIL midrst_err: got %b want 0", err); end
    s_data_ok = 1; s_rdata = 32'hCAFE_F00D; #1;
    n_cmp++; if ({m0_data_ok, m1_data_ok} !== 2'b00) begin
      n_bad++; $display("FAIL midrst_discard: got %b want 00", {m0_data_ok, m1_data_ok}); end
    step();
    s_data_ok = 0; #1;
    n_cmp++; if (err !== 1'b1) begin
      n_bad++; $display("FAIL midrst_late_dok: got %b want 1", err); end
  endtask

  initial begin
    idle();
    ARESET = 1;
    step();
    test_reset();
    test_tie_and_full();
    test_hold();
    test_return_order();
    test_empty_data_ok();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/srambus_arbiter.md
SRAMBUS_ARBITER -- requirements
Module: srambus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, request address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter MASK_W, default 4, write byte-mask width.
REQ-004 SHALL have parameter DEPTH, default 4, outstanding-transaction limit; power of 2, minimum 2.
REQ-005 SHALL have port ACLK, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port ARESET, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have, per requester port mN (N=0 fetch, N=1 data), inputs mN_req 1, mN_ren 1, mN_wen 1, mN_address ADDR_W, mN_wdata DATA_W, mN_wmask MASK_W, mN_size 3, mN_match_id 3, mN_data_resp 1.
REQ-008 SHALL have, per requester port, outputs mN_addr_ok 1, mN_data_ok 1, mN_rdata DATA_W.
REQ-009 SHALL have downstream outputs s_req, s_ren, s_wen, s_address, s_wdata, s_wmask, s_size, s_match_id, s_data_resp, widths as in REQ-007.
REQ-010 SHALL have downstream inputs s_addr_ok 1, s_data_ok 1, s_rdata DATA_W.
REQ-011 SHALL have output err 1: sticky protocol-error flag.

Function
REQ-012 SHALL run a 2-state grant FSM: ARB and HOLD, plus a grant register gnt (0/1) and a last-served register lst.
REQ-013 In ARB, if both mN_req are high, SHALL grant the requester not equal to lst (round-robin); if one is high, SHALL grant it.
REQ-014 In ARB, the grant SHALL be combinational in the same cycle, so a request can be forwarded and accepted with zero added latency.
REQ-015 SHALL drive s_req = granted mN_req AND NOT full; all s_* request fields SHALL be muxed from the granted port.
REQ-016 SHALL drive mN_addr_ok = s_addr_ok AND s_req AND (grant == N); the non-granted port's addr_ok SHALL be 0.
REQ-017 If s_req is high and s_addr_ok is low, the FSM SHALL move to HOLD and register the grant; in HOLD the grant SHALL NOT change regardless of the other requester.
REQ-018 HOLD SHALL return to ARB on the cycle s_req AND s_addr_ok; lst SHALL update to the granted index on every accepted handshake.
REQ-019 If the held requester drops mN_req in HOLD, the FSM SHALL return to ARB next cycle and set err.
REQ-020 SHALL keep an in-order owner FIFO of DEPTH entries, 1 bit each, with a count register 0..DEPTH.
REQ-021 On each accepted address handshake, SHALL push the granted index.
REQ-022 On s_data_ok with the FIFO non-empty, SHALL pop; mHEAD_data_ok SHALL equal s_data_ok and mHEAD_rdata SHALL equal s_rdata, where HEAD is the FIFO head.
REQ-023 The non-head port SHALL see data_ok 0 and rdata 0.
REQ-024 s_data_resp SHALL equal mHEAD_data_resp when the FIFO is non-empty, else 0.
REQ-025 Full (count == DEPTH) SHALL block s_req even when a pop occurs in the same cycle.
REQ-026 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance; pointers SHALL wrap modulo DEPTH.
REQ-027 s_data_ok while empty SHALL be ignored (no pop, no data_ok to any port) and SHALL set err.
REQ-028 The arbiter SHALL add no cycle of latency on the data-return path (purely combinational routing from the FIFO head).

Reset
REQ-029 While ARESET is high at a clock edge: FSM SHALL go to ARB, gnt=0, lst=1 (so m0 wins the first tie), count=0, pointers=0, err=0.
REQ-030 During and after reset with no requests, all outputs SHALL be 0.
REQ-031 Reset mid-transaction SHALL discard all outstanding owner entries; later s_data_ok SHALL be treated as in REQ-027.

Verification
REQ-032 Tie with m0_req=m1_req=1 and s_addr_ok=1 for 4 cycles after reset -> grants alternate 0,1,0,1 and the FIFO holds 0,1,0,1.
REQ-033 m1 requests with s_addr_ok=0 for 3 cycles while m0 requests -> HOLD keeps m1 and m0_addr_ok stays 0; on the 4th cycle s_addr_ok=1 -> m1_addr_ok=1, then m0 is granted the next cycle.
REQ-034 DEPTH=4 outstanding with no data_ok -> s_req=0 while requests are held; pop and request in the same cycle -> still blocked; next cycle -> accepted.
REQ-035 Push m0 then m1; return s_data_ok with s_rdata=0xDEADBEEF, then 0x12345678 -> m0 gets 0xDEADBEEF and m1 gets 0x12345678, one data_ok each.
REQ-036 s_data_ok pulse with an empty FIFO -> no data_ok to either port and err=1 until ARESET.
REQ-037 Assert ARESET with 2 entries outstanding -> count=0 and err=0 next cycle.
